// File: rtl/intlv_pkg.sv
// Shared constants for the QPP interleaver RAM controller:
// state encoding, widths, link base offsets and the mod-K add helper.
package intlv_pkg;

  localparam int unsigned ADDRESS     = 16;
  localparam int unsigned KW          = 13;
  localparam int unsigned SW          = KW + 1;
  localparam int unsigned LINK_STRIDE = 6144;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    PREP  = 2'd2,
    READ  = 2'd3
  } state_t;

  // Each link owns one maximum-size block of RAM, so bases step by the largest K.
  function automatic logic [ADDRESS-1:0] link_base(input logic [1:0] id);
    return ADDRESS'(32'(id) * LINK_STRIDE);
  endfunction

  // Operands are already below k, so one conditional subtract is enough.
  function automatic logic [KW-1:0] mod_add(input logic [KW-1:0] a,
                                            input logic [KW-1:0] b,
                                            input logic [KW-1:0] k);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return (s >= SW'(k)) ? KW'(s - SW'(k)) : KW'(s);
  endfunction

endpackage

// File: rtl/intlv_ram_ctrl_if.sv
// Single-port synchronous RAM bus (1-cycle read latency) between controller and RAM.
interface intlv_ram_ctrl_if #(
  parameter int unsigned DW      = 8,
  parameter int unsigned ADDRESS = 16
);
  logic [ADDRESS-1:0] ram_addr;
  logic               ram_we;
  logic [DW-1:0]      ram_wdata;
  logic [DW-1:0]      ram_rdata;

  modport master (output ram_addr, output ram_we, output ram_wdata, input ram_rdata);
  modport slave  (input ram_addr, input ram_we, input ram_wdata, output ram_rdata);
endinterface

// File: rtl/qpp_step.sv
// One step of the QPP recursion: pi' = (pi + g) mod K, g' = (g + 2*f2) mod K.
module qpp_step
  import intlv_pkg::*;
(
  input  logic [KW-1:0] pi,
  input  logic [KW-1:0] g,
  input  logic [KW-1:0] k,
  input  logic [KW-1:0] f2x2,
  output logic [KW-1:0] pi_nxt_c,
  output logic [KW-1:0] g_nxt_c
);

  always_comb begin
    pi_nxt_c = mod_add(pi, g, k);
    g_nxt_c  = mod_add(g, f2x2, k);
  end

endmodule

// File: rtl/intlv_ram_ctrl.sv
// QPP interleaver RAM controller: linear block write, then interleaved read-back.
// Optional sticky protocol error output enabled by defining INTLV_ERR_CHK_EN.
module intlv_ram_ctrl #(
  parameter int unsigned DW      = 8,
  parameter int unsigned ADDRESS = 16
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    wen,
  input  logic [ADDRESS-1:0]      enable,
  input  logic [ADDRESS-1:0]      id_offset,
  input  logic                    rd_req,
  input  logic [intlv_pkg::KW-1:0] m_len,
  input  logic [intlv_pkg::KW-1:0] f1,
  input  logic [intlv_pkg::KW-1:0] f2,
  input  logic [DW-1:0]           din,
  intlv_ram_ctrl_if.master        ram,
  output logic [DW-1:0]           dout,
  output logic                    dout_vld,
  output logic                    busy
`ifdef INTLV_ERR_CHK_EN
  ,
  output logic                    err
`endif
);
  import intlv_pkg::*;

  state_t        state;
  logic [KW-1:0] k, pi, g, f2x2, idx;
  logic [KW-1:0] pi_nxt_c, g_nxt_c, last_wr_c;
  logic [1:0]    rd_pipe;
  logic          k_small_c, wr_last_c, rd_acc_c;

  qpp_step u_qpp_step (
    .pi       (pi),
    .g        (g),
    .k        (k),
    .f2x2     (f2x2),
    .pi_nxt_c (pi_nxt_c),
    .g_nxt_c  (g_nxt_c)
  );

  // K of 0 or 1 degenerates to a single-entry block so neither phase can stall.
  always_comb begin
    k_small_c = (m_len <= KW'(1));
    last_wr_c = k_small_c ? '0 : m_len - KW'(1);
    wr_last_c = (enable == ADDRESS'(last_wr_c));
    rd_acc_c  = (state == READ) && rd_req;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      k             <= '0;
      pi            <= '0;
      g             <= '0;
      f2x2          <= '0;
      idx           <= '0;
      rd_pipe       <= '0;
      ram.ram_addr  <= '0;
      ram.ram_we    <= 1'b0;
      ram.ram_wdata <= '0;
      dout          <= '0;
      dout_vld      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      ram.ram_we <= 1'b0;
      // Two stages cover the address register plus the RAM's read latency.
      rd_pipe    <= {rd_pipe[0], rd_acc_c};
      dout_vld   <= rd_pipe[1];
      if (rd_pipe[1]) dout <= ram.ram_rdata;

      case (state)
        IDLE, WRITE: begin
          if (wen) begin
            ram.ram_we    <= 1'b1;
            ram.ram_addr  <= id_offset + enable;
            ram.ram_wdata <= din;
            busy          <= 1'b1;
            state         <= wr_last_c ? PREP : WRITE;
          end
        end
        PREP: begin
          k     <= k_small_c ? KW'(1) : m_len;
          g     <= k_small_c ? '0 : mod_add(f1, f2, m_len);
          f2x2  <= k_small_c ? '0 : mod_add(f2, f2, m_len);
          pi    <= '0;
          idx   <= '0;
          state <= READ;
        end
        READ: begin
          if (rd_req) begin
            ram.ram_addr <= id_offset + ADDRESS'(pi);
            pi           <= pi_nxt_c;
            g            <= g_nxt_c;
            idx          <= idx + KW'(1);
            if (idx == k - KW'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INTLV_ERR_CHK_EN
  logic [KW-1:0] wr_exp;

  // Sticky: out-of-order write index or zero block length.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err    <= 1'b0;
      wr_exp <= '0;
    end else begin
      if ((state == IDLE || state == WRITE) && wen) begin
        if (enable != ADDRESS'(wr_exp)) err <= 1'b1;
        wr_exp <= wr_last_c ? '0 : wr_exp + KW'(1);
      end
      if (state == PREP && m_len == '0) err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_intlv_ram_ctrl.sv
// Bench for intlv_ram_ctrl: directed blocks, RAM model and dout scoreboard.
module tb_intlv_ram_ctrl;
  import intlv_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;

  logic          clk, n_rst, wen, rd_req;
  logic [AW-1:0] enable, id_offset;
  logic [12:0]   m_len, f1, f2;
  logic [DW-1:0] din, dout;
  logic          dout_vld, busy;
`ifdef INTLV_ERR_CHK_EN
  logic          err;
`endif

  intlv_ram_ctrl_if #(.DW(DW), .ADDRESS(AW)) ram_if ();

  intlv_ram_ctrl #(.DW(DW), .ADDRESS(AW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .wen       (wen),
    .enable    (enable),
    .id_offset (id_offset),
    .rd_req    (rd_req),
    .m_len     (m_len),
    .f1        (f1),
    .f2        (f2),
    .din       (din),
    .ram       (ram_if),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .busy      (busy)
`ifdef INTLV_ERR_CHK_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [65536] = '{default: '0};
  always @(posedge clk) begin
    ram_if.ram_rdata <= mem[ram_if.ram_addr];
    if (ram_if.ram_we) mem[ram_if.ram_addr] = ram_if.ram_wdata;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;
  exp_t exp_q[$];
  bit   seen [8192];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, act, want, cyc);
    end
  endtask

  function automatic logic [7:0] dat(input int i, input int sel);
    case (sel)
      0:       return 8'(i);
      1:       return 8'(i + 64);
      2:       return 8'(i * 7 + 1);
      default: return 8'(i ^ 90);
    endcase
  endfunction

  // Closed-form QPP: pi(n) = (f1*n + f2*n^2) mod K
  function automatic int pi_ref(input int n, input int k, input int a, input int b);
    longint t;
    if (k <= 1) return 0;
    t = longint'(a) * n + longint'(b) * n * n;
    return int'(t % k);
  endfunction

  // Scoreboard: every dout_vld pulse must match the oldest expected read and its cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (dout_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dout_vld_unexpected: got pulse (dout 0x%0h) want none at cycle %0d", dout, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("dout", 32'(dout), 32'(e.d));
        chk("dout_latency_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  task automatic write_block(input int k, input logic [15:0] off, input int a, input int b,
                             input int sel, input bit noise, input bit junk);
    int kk;
    kk = (k <= 1) ? 1 : k;
    m_len = 13'(k);
    f1 = 13'(a);
    f2 = 13'(b);
    id_offset = off;
    for (int i = 0; i < kk; i++) begin
      wen = 1'b1;
      enable = 16'(i);
      din = dat(i, sel);
      rd_req = noise && (i % 3 == 0);
      @(posedge clk); #1;
    end
    rd_req = 1'b0;
    if (junk) begin
      wen = 1'b1;
      enable = '0;
      din = 8'hEE;
    end else begin
      wen = 1'b0;
    end
  endtask

  task automatic read_block(input int k, input logic [15:0] off, input int a, input int b,
                            input int sel, input bit stall);
    int kk, n, step, p, obs;
    logic [15:0] ea, last_a;
    exp_t e;
    kk = (k <= 1) ? 1 : k;
    for (int i = 0; i < 8192; i++) seen[i] = 1'b0;
    @(posedge clk); #1;
    wen = 1'b0;
    n = 0;
    step = 0;
    last_a = '0;
    while (n < kk) begin
      if (stall && (step == 1 || step == 2)) begin
        rd_req = 1'b0;
        @(posedge clk); #1;
        chk("stall_addr", 32'(ram_if.ram_addr), 32'(last_a));
      end else begin
        p = pi_ref(n, kk, a, b);
        rd_req = 1'b1;
        e.d = dat(p, sel);
        e.c = cyc + 3;
        exp_q.push_back(e);
        @(posedge clk); #1;
        ea = off + 16'(p);
        chk("rd_addr", 32'(ram_if.ram_addr), 32'(ea));
        chk("rd_we", 32'(ram_if.ram_we), 32'(0));
        chk("rd_busy", 32'(busy), (n == kk - 1) ? 32'(0) : 32'(1));
        obs = int'(16'(ram_if.ram_addr - off));
        checks++;
        if (obs >= kk) begin
          errors++;
          $display("FAIL pi_range: got pi %0d want below %0d", obs, kk);
        end else if (seen[obs]) begin
          errors++;
          $display("FAIL pi_unique: got repeated pi %0d want distinct at read %0d", obs, n);
        end else begin
          seen[obs] = 1'b1;
        end
        last_a = ea;
        n++;
      end
      step++;
    end
    rd_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ram_we"}, 32'(ram_if.ram_we), 32'(0));
    chk({tag, "_ram_addr"}, 32'(ram_if.ram_addr), 32'(0));
    chk({tag, "_ram_wdata"}, 32'(ram_if.ram_wdata), 32'(0));
    chk({tag, "_dout"}, 32'(dout), 32'(0));
    chk({tag, "_dout_vld"}, 32'(dout_vld), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst = 1'b0; wen = 1'b0; rd_req = 1'b0; enable = '0; id_offset = '0;
    m_len = '0; f1 = '0; f2 = '0; din = '0;
    repeat (3) @(posedge clk); #1;
    chk_reset_outputs("por");
    n_rst = 1'b1;

    // Read requests in IDLE must be ignored
    rd_req = 1'b1;
    repeat (3) @(posedge clk); #1;
    rd_req = 1'b0;
    chk("idle_busy", 32'(busy), 32'(0));

    // Main block, rd_req noise during writes, stray wen during PREP
    write_block(40, 16'h12ae, 3, 10, 0, 1'b1, 1'b1);
    read_block(40, 16'h12ae, 3, 10, 0, 1'b0);
    chk("t1_busy_end", 32'(busy), 32'(0));

    // Next block starts on the cycle after the final read; reads stall 1,0,0,1
    write_block(40, 16'h0100, 3, 10, 1, 1'b0, 1'b0);
    read_block(40, 16'h0100, 3, 10, 1, 1'b1);

    // Address wrap through 0xffff
    write_block(40, 16'hfff0, 3, 10, 2, 1'b0, 1'b0);
    read_block(40, 16'hfff0, 3, 10, 2, 1'b0);
    chk("wrap_mem_ffff", 32'(mem[16'hffff]), 32'(dat(15, 2)));
    chk("wrap_mem_0000", 32'(mem[0]), 32'(dat(16, 2)));

    // Reset during write index 20
    m_len = 13'd40; f1 = 13'd3; f2 = 13'd10; id_offset = 16'h2000;
    for (int i = 0; i < 20; i++) begin
      wen = 1'b1; enable = 16'(i); din = dat(i, 0);
      @(posedge clk); #1;
    end
    wen = 1'b1; enable = 16'd20; din = dat(20, 0);
    #2 n_rst = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    wen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_ram_we", 32'(ram_if.ram_we), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_dout_vld", 32'(dout_vld), 32'(0));
    end
    n_rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mem_idx18", 32'(mem[16'h2012]), 32'(dat(18, 0)));
    chk("rst_mem_idx19", 32'(mem[16'h2013]), 32'(0));
    chk("rst_mem_idx20", 32'(mem[16'h2014]), 32'(0));

    // Degenerate block lengths
    write_block(1, link_base(2'd3), 5, 7, 3, 1'b0, 1'b0);
    read_block(1, link_base(2'd3), 5, 7, 3, 1'b0);
    chk("k1_busy_end", 32'(busy), 32'(0));
    write_block(0, 16'h5000, 5, 7, 3, 1'b0, 1'b0);
    read_block(0, 16'h5000, 5, 7, 3, 1'b0);
    chk("k0_busy_end", 32'(busy), 32'(0));
`ifdef INTLV_ERR_CHK_EN
    chk("err_k0", 32'(err), 32'(1));
`endif

    // Largest block length
    write_block(6144, link_base(2'd1), 263, 480, 0, 1'b0, 1'b0);
    read_block(6144, link_base(2'd1), 263, 480, 0, 1'b0);
    chk("k6144_busy_end", 32'(busy), 32'(0));
`ifdef INTLV_ERR_CHK_EN
    chk("err_sticky", 32'(err), 32'(1));
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding reads want 0", exp_q.size());
    end
    repeat (3) @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
